branch_resolve_ctrl: RTL and testbench

- Sequencing controller for conditional-branch and jump resolution in the RV32I core.
- Accepts one branch per handshake from decode/execute and drives an internal branch_comp instance, including BrUn selection from funct3.
- Decides taken/not-taken, compares the outcome against the fetch prediction, and on mispredict issues a held redirect to fetch followed by a fixed-length pipeline flush.
- Maintains a mispredict performance counter.

---
 rtl/branch_pkg.sv | 19 +
 rtl/branch_comp.sv | 16 +
 rtl/branch_resolve_ctrl.sv | 158 +++++++++++++++
 tb/tb_branch_resolve_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolution controller:
// B-type funct3 encodings and the controller state type.
package branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    RESOLVE,
    REDIRECT,
    FLUSH
  } br_state_t;

endpackage

// File: rtl/branch_comp.sv
// Operand comparator for conditional branches; br_un selects an unsigned
// less-than, otherwise the operands compare as two's-complement values.
module branch_comp #(
  parameter int n = 32
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         br_un,
  output logic         br_eq,
  output logic         br_lt
);

  assign br_eq = (a == b);
  assign br_lt = br_un ? (a < b) : ($signed(a) < $signed(b));

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Resolves one branch per handshake, checks it against the fetch prediction,
// and on a mispredict issues a held redirect followed by a fixed-length flush.
module branch_resolve_ctrl
  import branch_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             br_valid,
  output logic             br_ready,
  input  logic [2:0]       br_funct3,
  input  logic             br_is_jump,
  input  logic             br_pred_taken,
  input  logic [XLEN-1:0]  br_rs1,
  input  logic [XLEN-1:0]  br_rs2,
  input  logic [XLEN-1:0]  br_pc,
  input  logic [XLEN-1:0]  br_target,
  output logic             resolved_valid,
  output logic             resolved_taken,
  output logic             illegal_funct3,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  input  logic             redirect_ack,
  output logic             flush,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int FW = $clog2(FLUSH_CYCLES + 2);

  br_state_t state, state_next;

  logic [2:0]      funct3_q;
  logic            is_jump_q;
  logic            pred_q;
  logic [XLEN-1:0] rs1_q, rs2_q, pc_q, target_q;
  logic [FW-1:0]   flush_cnt;

  logic br_un, br_eq, br_lt;
  logic taken_c, illegal_c, mispredict_c;

  // funct3[1] distinguishes the unsigned BLTU/BGEU forms from BLT/BGE.
  assign br_un = funct3_q[1];

  branch_comp #(.n(XLEN)) u_comp (
    .a     (rs1_q),
    .b     (rs2_q),
    .br_un (br_un),
    .br_eq (br_eq),
    .br_lt (br_lt)
  );

  always_comb begin
    taken_c   = 1'b0;
    illegal_c = 1'b0;
    case (funct3_q)
      F3_BEQ:           taken_c = br_eq;
      F3_BNE:           taken_c = !br_eq;
      F3_BLT, F3_BLTU:  taken_c = br_lt;
      F3_BGE, F3_BGEU:  taken_c = !br_lt;
      default:          illegal_c = 1'b1;
    endcase
    if (is_jump_q) begin
      taken_c   = 1'b1;
      illegal_c = 1'b0;
    end
  end

  assign mispredict_c = (taken_c != pred_q);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    br_ready   = 1'b0;
    flush      = 1'b0;
    case (state)
      IDLE: begin
        br_ready = 1'b1;
        if (br_valid) state_next = RESOLVE;
      end
      RESOLVE: begin
        state_next = mispredict_c ? REDIRECT : IDLE;
      end
      REDIRECT: begin
        if (redirect_ack) state_next = (FLUSH_CYCLES > 0) ? FLUSH : IDLE;
      end
      FLUSH: begin
        flush = 1'b1;
        if (flush_cnt == FW'(1)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand latch, result pulses, redirect register and the two counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      funct3_q         <= '0;
      is_jump_q        <= 1'b0;
      pred_q           <= 1'b0;
      rs1_q            <= '0;
      rs2_q            <= '0;
      pc_q             <= '0;
      target_q         <= '0;
      resolved_valid   <= 1'b0;
      resolved_taken   <= 1'b0;
      illegal_funct3   <= 1'b0;
      redirect_valid   <= 1'b0;
      redirect_pc      <= '0;
      flush_cnt        <= '0;
      mispredict_count <= '0;
    end else begin
      resolved_valid <= 1'b0;
      resolved_taken <= 1'b0;
      illegal_funct3 <= 1'b0;
      case (state)
        IDLE: begin
          if (br_valid) begin
            funct3_q  <= br_funct3;
            is_jump_q <= br_is_jump;
            pred_q    <= br_pred_taken;
            rs1_q     <= br_rs1;
            rs2_q     <= br_rs2;
            pc_q      <= br_pc;
            target_q  <= br_target;
          end
        end
        RESOLVE: begin
          resolved_valid <= 1'b1;
          resolved_taken <= taken_c;
          illegal_funct3 <= illegal_c;
          if (mispredict_c) begin
            redirect_valid   <= 1'b1;
            redirect_pc      <= taken_c ? target_q : pc_q + XLEN'(4);
            mispredict_count <= mispredict_count + 1'b1;
          end
        end
        REDIRECT: begin
          if (redirect_ack) begin
            redirect_valid <= 1'b0;
            flush_cnt      <= FW'(FLUSH_CYCLES);
          end
        end
        FLUSH: begin
          flush_cnt <= flush_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl: main instance with default
// parameters plus a CNT_W=2, FLUSH_CYCLES=0 instance for counter wrap.
module tb_branch_resolve_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        br_valid = 1'b0, br_is_jump = 1'b0, br_pred_taken = 1'b0;
  logic [2:0]  br_funct3 = 3'b000;
  logic [31:0] br_rs1 = '0, br_rs2 = '0, br_pc = '0, br_target = '0;
  logic        redirect_ack = 1'b0;
  logic        br_ready, resolved_valid, resolved_taken, illegal_funct3;
  logic        redirect_valid, flush;
  logic [31:0] redirect_pc;
  logic [15:0] mispredict_count;

  logic        b_valid = 1'b0, b_pred = 1'b0, b_ack = 1'b0;
  logic [2:0]  b_funct3 = 3'b000;
  logic [31:0] b_rs1 = '0, b_rs2 = '0;
  logic        b_ready, b_rvalid, b_rtaken, b_illegal, b_redirect_valid, b_flush;
  logic [31:0] b_redirect_pc;
  logic [1:0]  b_count;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  branch_resolve_ctrl dut (
    .clk(clk), .rst(rst),
    .br_valid(br_valid), .br_ready(br_ready), .br_funct3(br_funct3),
    .br_is_jump(br_is_jump), .br_pred_taken(br_pred_taken),
    .br_rs1(br_rs1), .br_rs2(br_rs2), .br_pc(br_pc), .br_target(br_target),
    .resolved_valid(resolved_valid), .resolved_taken(resolved_taken),
    .illegal_funct3(illegal_funct3), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .redirect_ack(redirect_ack), .flush(flush),
    .mispredict_count(mispredict_count)
  );

  branch_resolve_ctrl #(.XLEN(32), .FLUSH_CYCLES(0), .CNT_W(2)) dut_small (
    .clk(clk), .rst(rst),
    .br_valid(b_valid), .br_ready(b_ready), .br_funct3(b_funct3),
    .br_is_jump(1'b0), .br_pred_taken(b_pred),
    .br_rs1(b_rs1), .br_rs2(b_rs2), .br_pc(32'h0000_0040), .br_target(32'h0000_0080),
    .resolved_valid(b_rvalid), .resolved_taken(b_rtaken),
    .illegal_funct3(b_illegal), .redirect_valid(b_redirect_valid),
    .redirect_pc(b_redirect_pc), .redirect_ack(b_ack), .flush(b_flush),
    .mispredict_count(b_count)
  );

  // Waits (bounded) for br_ready, presents one request for a single edge,
  // and returns at the falling edge where the controller is in RESOLVE.
  task automatic issue(input logic [2:0] f3, input logic jmp, input logic pred,
                       input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] pc, input logic [31:0] tgt);
    int waited = 0;
    while (br_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    vectors++;
    if (br_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL issue_ready: br_ready got %b want 1", br_ready);
    end
    br_funct3 = f3; br_is_jump = jmp; br_pred_taken = pred;
    br_rs1 = rs1; br_rs2 = rs2; br_pc = pc; br_target = tgt;
    br_valid = 1'b1;
    @(negedge clk);
    br_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({br_ready, resolved_valid, resolved_taken, illegal_funct3, redirect_valid, flush} !== 6'b100000) begin
      errors++;
      $display("[TB] FAIL reset_flags: got %b want 100000",
               {br_ready, resolved_valid, resolved_taken, illegal_funct3, redirect_valid, flush});
    end
    vectors++;
    if (redirect_pc !== 32'h0 || mispredict_count !== 16'h0) begin
      errors++;
      $display("[TB] FAIL reset_regs: pc %h cnt %0d want 0 0", redirect_pc, mispredict_count);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_beq_predicted;
    issue(3'b000, 1'b0, 1'b1, 32'd5, 32'd5, 32'h0000_0010, 32'h0000_0020);
    vectors++;
    if (resolved_valid !== 1'b0 || br_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL beq_resolve_phase: rv %b ready %b want 0 0", resolved_valid, br_ready);
    end
    @(negedge clk);
    vectors++;
    if ({resolved_valid, resolved_taken, illegal_funct3, redirect_valid, br_ready} !== 5'b11001) begin
      errors++;
      $display("[TB] FAIL beq_result: got %b want 11001",
               {resolved_valid, resolved_taken, illegal_funct3, redirect_valid, br_ready});
    end
    vectors++;
    if (mispredict_count !== 16'd0) begin
      errors++;
      $display("[TB] FAIL beq_count: got %0d want 0", mispredict_count);
    end
    @(negedge clk);
    vectors++;
    if (resolved_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL beq_pulse_width: resolved_valid got %b want 0", resolved_valid);
    end
  endtask

  task automatic test_blt_mispredict;
    issue(3'b100, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h0000_0100, 32'h0000_0200);
    @(negedge clk);
    vectors++;
    if ({resolved_valid, resolved_taken, redirect_valid, br_ready} !== 4'b1110) begin
      errors++;
      $display("[TB] FAIL blt_result: got %b want 1110",
               {resolved_valid, resolved_taken, redirect_valid, br_ready});
    end
    vectors++;
    if (redirect_pc !== 32'h0000_0200 || mispredict_count !== 16'd1) begin
      errors++;
      $display("[TB] FAIL blt_redirect: pc %h cnt %0d want 00000200 1", redirect_pc, mispredict_count);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0000_0200 || flush !== 1'b0) begin
        errors++;
        $display("[TB] FAIL blt_hold%0d: rv %b pc %h flush %b want 1 00000200 0",
                 i, redirect_valid, redirect_pc, flush);
      end
    end
    redirect_ack = 1'b1;
    @(negedge clk);
    redirect_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (flush !== 1'b1 || redirect_valid !== 1'b0 || br_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL blt_flush%0d: flush %b rv %b ready %b want 1 0 0",
                 i, flush, redirect_valid, br_ready);
      end
      @(negedge clk);
    end
    vectors++;
    if (flush !== 1'b0 || br_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL blt_flush_end: flush %b ready %b want 0 1", flush, br_ready);
    end
  endtask

  task automatic test_bltu_early_ack;
    issue(3'b110, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'h0000_0100, 32'h0000_0200);
    vectors++;
    if (dut.br_un !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bltu_brun: got %b want 1", dut.br_un);
    end
    @(negedge clk);
    vectors++;
    if ({resolved_valid, resolved_taken, redirect_valid} !== 3'b101 ||
        redirect_pc !== 32'h0000_0104 || mispredict_count !== 16'd2) begin
      errors++;
      $display("[TB] FAIL bltu_result: flags %b pc %h cnt %0d want 101 00000104 2",
               {resolved_valid, resolved_taken, redirect_valid}, redirect_pc, mispredict_count);
    end
    redirect_ack = 1'b1;
    @(negedge clk);
    redirect_ack = 1'b0;
    vectors++;
    if (flush !== 1'b1 || redirect_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bltu_early_ack: flush %b rv %b want 1 0", flush, redirect_valid);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_illegal_and_jump;
    issue(3'b010, 1'b0, 1'b1, 32'd7, 32'd7, 32'h0000_0300, 32'h0000_0400);
    @(negedge clk);
    vectors++;
    if ({resolved_valid, resolved_taken, illegal_funct3, redirect_valid} !== 4'b1011 ||
        redirect_pc !== 32'h0000_0304 || mispredict_count !== 16'd3) begin
      errors++;
      $display("[TB] FAIL illegal_result: flags %b pc %h cnt %0d want 1011 00000304 3",
               {resolved_valid, resolved_taken, illegal_funct3, redirect_valid}, redirect_pc, mispredict_count);
    end
    redirect_ack = 1'b1;
    @(negedge clk);
    redirect_ack = 1'b0;
    vectors++;
    if (illegal_funct3 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL illegal_pulse_width: got %b want 0", illegal_funct3);
    end
    issue(3'b010, 1'b1, 1'b1, 32'd7, 32'd8, 32'h0000_0300, 32'h0000_0400);
    @(negedge clk);
    vectors++;
    if ({resolved_valid, resolved_taken, illegal_funct3, redirect_valid} !== 4'b1100 ||
        mispredict_count !== 16'd3) begin
      errors++;
      $display("[TB] FAIL jump_result: flags %b cnt %0d want 1100 3",
               {resolved_valid, resolved_taken, illegal_funct3, redirect_valid}, mispredict_count);
    end
  endtask

  task automatic test_pc_wrap;
    issue(3'b001, 1'b0, 1'b1, 32'd9, 32'd9, 32'hFFFF_FFFC, 32'h0000_0500);
    @(negedge clk);
    vectors++;
    if (resolved_taken !== 1'b0 || redirect_valid !== 1'b1 || redirect_pc !== 32'h0000_0000 ||
        mispredict_count !== 16'd4) begin
      errors++;
      $display("[TB] FAIL pc_wrap: taken %b rv %b pc %h cnt %0d want 0 1 00000000 4",
               resolved_taken, redirect_valid, redirect_pc, mispredict_count);
    end
    redirect_ack = 1'b1;
    @(negedge clk);
    redirect_ack = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back;
    issue(3'b001, 1'b0, 1'b1, 32'd1, 32'd2, 32'h0000_0600, 32'h0000_0700);
    @(negedge clk);
    vectors++;
    if (resolved_valid !== 1'b1 || br_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_first: rv %b ready %b want 1 1", resolved_valid, br_ready);
    end
    br_funct3 = 3'b111; br_pred_taken = 1'b0; br_rs1 = 32'd3; br_rs2 = 32'd3;
    br_valid = 1'b1;
    @(negedge clk);
    br_valid = 1'b0;
    vectors++;
    if (resolved_valid !== 1'b0 || br_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_accept: rv %b ready %b want 0 0", resolved_valid, br_ready);
    end
    @(negedge clk);
    vectors++;
    if ({resolved_valid, resolved_taken, redirect_valid} !== 3'b111 ||
        redirect_pc !== 32'h0000_0700 || mispredict_count !== 16'd5) begin
      errors++;
      $display("[TB] FAIL b2b_second: flags %b pc %h cnt %0d want 111 00000700 5",
               {resolved_valid, resolved_taken, redirect_valid}, redirect_pc, mispredict_count);
    end
    redirect_ack = 1'b1;
    @(negedge clk);
    redirect_ack = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    issue(3'b000, 1'b0, 1'b0, 32'd4, 32'd4, 32'h0000_0800, 32'h0000_0900);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if ({redirect_valid, flush, br_ready} !== 3'b001 || mispredict_count !== 16'd0) begin
      errors++;
      $display("[TB] FAIL reset_in_redirect: rv/flush/ready %b cnt %0d want 001 0",
               {redirect_valid, flush, br_ready}, mispredict_count);
    end
    issue(3'b000, 1'b0, 1'b0, 32'd4, 32'd4, 32'h0000_0800, 32'h0000_0900);
    @(negedge clk);
    redirect_ack = 1'b1;
    @(negedge clk);
    redirect_ack = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if ({redirect_valid, flush, br_ready} !== 3'b001 || mispredict_count !== 16'd0) begin
      errors++;
      $display("[TB] FAIL reset_in_flush: rv/flush/ready %b cnt %0d want 001 0",
               {redirect_valid, flush, br_ready}, mispredict_count);
    end
    issue(3'b101, 1'b0, 1'b1, 32'd10, 32'hFFFF_FFF0, 32'h0000_0a00, 32'h0000_0b00);
    @(negedge clk);
    vectors++;
    if ({resolved_valid, resolved_taken, redirect_valid, br_ready} !== 4'b1101) begin
      errors++;
      $display("[TB] FAIL after_reset_branch: got %b want 1101",
               {resolved_valid, resolved_taken, redirect_valid, br_ready});
    end
  endtask

  task automatic test_count_wrap;
    logic [1:0] want;
    for (int i = 1; i <= 4; i++) begin
      want = 2'(i);
      b_funct3 = 3'b000; b_pred = 1'b1; b_rs1 = 32'd1; b_rs2 = 32'd2;
      b_valid = 1'b1;
      @(negedge clk);
      b_valid = 1'b0;
      @(negedge clk);
      vectors++;
      if (b_redirect_valid !== 1'b1 || b_redirect_pc !== 32'h0000_0044 || b_count !== want) begin
        errors++;
        $display("[TB] FAIL wrap_redirect%0d: rv %b pc %h cnt %0d want 1 00000044 %0d",
                 i, b_redirect_valid, b_redirect_pc, b_count, want);
      end
      b_ack = 1'b1;
      @(negedge clk);
      b_ack = 1'b0;
      vectors++;
      if ({b_redirect_valid, b_flush, b_ready} !== 3'b001) begin
        errors++;
        $display("[TB] FAIL wrap_noflush%0d: rv/flush/ready %b want 001",
                 i, {b_redirect_valid, b_flush, b_ready});
      end
    end
  endtask

  initial begin
    test_reset();
    test_beq_predicted();
    test_blt_mispredict();
    test_bltu_early_ack();
    test_illegal_and_jump();
    test_pc_wrap();
    test_back_to_back();
    test_reset_mid();
    test_count_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
